mem_lock_arbiter: RTL and testbench

- Shares the single main_mem port between C cores using round-robin arbitration.
- Returns a per-core access grant (main_mem_ac) to each core.
- Owns the lock table behind the lock_en/unlock_en/lock_ac interface, so a core can hold exclusive ownership of a 10-bit lock address.
- Sits between the core array and main_mem in the top level; main_mem read data stays broadcast to all cores.

---
 rtl/mem_lock_pkg.sv | 15 +
 rtl/mem_lock_arbiter_rr_arbiter.sv | 29 ++
 rtl/mem_lock_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_lock_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lock_pkg.sv
// Shared widths and types for the main_mem arbiter and lock table.
package mem_lock_pkg;

  localparam int ADR_W  = 16;
  localparam int LADR_W = 10;

  typedef logic [ADR_W-1:0]  adr_t;
  typedef logic [LADR_W-1:0] ladr_t;

  // Index width for a pointer over n requesters; never below one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_lock_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo C.
module rr_arbiter
  import mem_lock_pkg::*;
#(
  parameter int C  = 2,
  parameter int PW = ptr_w(C)
) (
  input  logic [C-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [C-1:0]  grant,
  output logic [PW-1:0] winner,
  output logic          any
);

  always_comb begin
    int idx;
    grant  = '0;
    winner = '0;
    any    = |req;
    idx    = 0;
    // Scan from the far end back toward ptr so the closest requester is written last.
    for (int k = C - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % C;
      if (req[idx]) winner = PW'(idx);
    end
    if (any) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/mem_lock_arbiter.sv
// Round-robin sharing of the main_mem port across C cores, plus a per-core
// exclusive lock table on LADR_W-bit lock addresses.
module mem_lock_arbiter
  import mem_lock_pkg::*;
#(
  parameter int C      = 2,
  parameter int ADR_W  = mem_lock_pkg::ADR_W,
  parameter int LADR_W = mem_lock_pkg::LADR_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [C-1:0]                main_mem_read,
  input  logic [C-1:0]                main_mem_write,
  input  logic [C-1:0][ADR_W-1:0]     main_mem_read_adr,
  input  logic [C-1:0][ADR_W-1:0]     main_mem_write_adr,
  input  logic [C-1:0][ADR_W-1:0]     main_mem_write_dat,
  output logic [C-1:0]                main_mem_ac,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADR_W-1:0]            mem_read_adr,
  output logic [ADR_W-1:0]            mem_write_adr,
  output logic [ADR_W-1:0]            mem_write_dat,
  input  logic [C-1:0][LADR_W-1:0]    lock_adr,
  input  logic [C-1:0]                lock_en,
  input  logic [C-1:0]                unlock_en,
  output logic [C-1:0]                lock_ac,
  output logic [C-1:0]                lock_held
);

  localparam int PW = ptr_w(C);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == C - 1) ? '0 : p + 1'b1;
  endfunction

  logic [C-1:0]  req;
  logic [C-1:0]  mgrant;
  logic [PW-1:0] mptr;
  logic [PW-1:0] mwin;
  logic          many;
  logic          mem_go;

  assign req    = main_mem_read | main_mem_write;
  assign mem_go = many & ~reset;

  rr_arbiter #(.C(C)) u_mem_arb (
    .req    (req),
    .ptr    (mptr),
    .grant  (mgrant),
    .winner (mwin),
    .any    (many)
  );

  always_comb begin
    main_mem_ac   = mem_go ? mgrant : '0;
    mem_read      = mem_go & main_mem_read[mwin];
    mem_write     = mem_go & main_mem_write[mwin];
    mem_read_adr  = mem_go ? main_mem_read_adr[mwin]  : '0;
    mem_write_adr = mem_go ? main_mem_write_adr[mwin] : '0;
    mem_write_dat = mem_go ? main_mem_write_dat[mwin] : '0;
  end

  logic [C-1:0]              valid;
  logic [C-1:0][LADR_W-1:0]  ladr;
  logic [PW-1:0]             lptr;
  logic [PW-1:0]             lptr_nxt;
  logic [C-1:0]              blocked;
  logic [C-1:0]              elig;
  logic [C-1:0][C-1:0]       group;
  logic [C-1:0][C-1:0]       lgrant;
  logic [C-1:0][PW-1:0]      lwin;
  logic [C-1:0]              lany;
  logic [C-1:0]              contested;

  // An address held by another core blocks everyone else, including a
  // requester racing that holder's unlock in the same cycle.
  always_comb begin
    for (int i = 0; i < C; i++) begin
      blocked[i] = 1'b0;
      for (int j = 0; j < C; j++)
        if (j != i && valid[j] && ladr[j] == lock_adr[i]) blocked[i] = 1'b1;
      elig[i] = lock_en[i] & ~unlock_en[i] & ~blocked[i] &
                (~valid[i] | (ladr[i] == lock_adr[i]));
    end
  end

  always_comb begin
    for (int i = 0; i < C; i++) begin
      for (int j = 0; j < C; j++)
        group[i][j] = elig[j] & (lock_adr[j] == lock_adr[i]);
      contested[i] = |(group[i] & (group[i] - 1'b1));
    end
  end

  for (genvar g = 0; g < C; g++) begin : g_lock_arb
    rr_arbiter #(.C(C)) u_lock_arb (
      .req    (group[g]),
      .ptr    (lptr),
      .grant  (lgrant[g]),
      .winner (lwin[g]),
      .any    (lany[g])
    );
  end

  always_comb begin
    lptr_nxt = lptr;
    for (int i = 0; i < C; i++) begin
      lock_ac[i] = ~reset & elig[i] & lany[i] & lgrant[i][i];
      if (lock_ac[i] && contested[i]) lptr_nxt = ptr_inc(lwin[i]);
    end
  end

  assign lock_held = valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      mptr  <= '0;
      lptr  <= '0;
      valid <= '0;
      ladr  <= '0;
    end else begin
      if (many) mptr <= ptr_inc(mwin);
      lptr <= lptr_nxt;
      for (int i = 0; i < C; i++) begin
        if (unlock_en[i]) begin
          valid[i] <= 1'b0;
        end else if (lock_ac[i]) begin
          valid[i] <= 1'b1;
          ladr[i]  <= lock_adr[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Directed and randomized bench for mem_lock_arbiter against an in-bench model.
module tb_mem_lock_arbiter;

  localparam int C  = 2;
  localparam int AW = 16;
  localparam int LW = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [C-1:0]          main_mem_read, main_mem_write, lock_en, unlock_en;
  logic [C-1:0][AW-1:0]  rd_adr, wr_adr, wr_dat;
  logic [C-1:0][LW-1:0]  lock_adr;
  logic [C-1:0]          main_mem_ac, lock_ac, lock_held;
  logic                  mem_read, mem_write;
  logic [AW-1:0]         mem_read_adr, mem_write_adr, mem_write_dat;

  mem_lock_arbiter #(.C(C), .ADR_W(AW), .LADR_W(LW)) dut (
    .clk                (clk),
    .reset              (reset),
    .main_mem_read      (main_mem_read),
    .main_mem_write     (main_mem_write),
    .main_mem_read_adr  (rd_adr),
    .main_mem_write_adr (wr_adr),
    .main_mem_write_dat (wr_dat),
    .main_mem_ac        (main_mem_ac),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_read_adr       (mem_read_adr),
    .mem_write_adr      (mem_write_adr),
    .mem_write_dat      (mem_write_dat),
    .lock_adr           (lock_adr),
    .lock_en            (lock_en),
    .unlock_en          (unlock_en),
    .lock_ac            (lock_ac),
    .lock_held          (lock_held)
  );

  int checks = 0;
  int errors = 0;

  // Model state: pointers as plain integers, lock table as arrays.
  int m_mptr, m_lptr;
  bit m_valid [C];
  int m_ladr  [C];

  logic [C-1:0]  e_ac, e_lac, e_held;
  logic          e_rd, e_wr;
  logic [AW-1:0] e_radr, e_wadr, e_wdat;
  int            e_win, lptr_next;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    main_mem_read = '0; main_mem_write = '0;
    rd_adr = '0; wr_adr = '0; wr_dat = '0;
    lock_en = '0; unlock_en = '0; lock_adr = '0;
  endtask

  task automatic model_eval();
    bit elig [C];
    int idx, first, n;
    e_ac = '0; e_lac = '0; e_rd = 1'b0; e_wr = 1'b0;
    e_radr = '0; e_wadr = '0; e_wdat = '0;
    e_win = -1; lptr_next = m_lptr;
    for (int i = 0; i < C; i++) e_held[i] = m_valid[i];
    if (!reset) begin
      for (int k = 0; k < C; k++) begin
        idx = (m_mptr + k) % C;
        if (e_win < 0 && (main_mem_read[idx] || main_mem_write[idx])) e_win = idx;
      end
      if (e_win >= 0) begin
        e_ac[e_win] = 1'b1;
        e_rd   = main_mem_read[e_win];
        e_wr   = main_mem_write[e_win];
        e_radr = rd_adr[e_win];
        e_wadr = wr_adr[e_win];
        e_wdat = wr_dat[e_win];
      end
      for (int i = 0; i < C; i++) begin
        elig[i] = lock_en[i] && !unlock_en[i];
        if (m_valid[i] && m_ladr[i] != int'(lock_adr[i])) elig[i] = 1'b0;
        for (int j = 0; j < C; j++)
          if (j != i && m_valid[j] && m_ladr[j] == int'(lock_adr[i])) elig[i] = 1'b0;
      end
      for (int i = 0; i < C; i++) begin
        if (elig[i]) begin
          first = -1; n = 0;
          for (int k = 0; k < C; k++) begin
            idx = (m_lptr + k) % C;
            if (elig[idx] && lock_adr[idx] == lock_adr[i]) begin
              n++;
              if (first < 0) first = idx;
            end
          end
          if (first == i) begin
            e_lac[i] = 1'b1;
            if (n > 1) lptr_next = (i + 1) % C;
          end
        end
      end
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_mptr = 0; m_lptr = 0;
      for (int i = 0; i < C; i++) m_valid[i] = 1'b0;
    end else begin
      if (e_win >= 0) m_mptr = (e_win + 1) % C;
      m_lptr = lptr_next;
      for (int i = 0; i < C; i++) begin
        if (unlock_en[i]) m_valid[i] = 1'b0;
        else if (e_lac[i]) begin
          m_valid[i] = 1'b1;
          m_ladr[i]  = int'(lock_adr[i]);
        end
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are compared 1 ns later.
  task automatic eval();
    #1;
    model_eval();
    chk("main_mem_ac", main_mem_ac, e_ac);
    chk("mem_read", mem_read, e_rd);
    chk("mem_write", mem_write, e_wr);
    chk("mem_read_adr", mem_read_adr, e_radr);
    chk("mem_write_adr", mem_write_adr, e_wadr);
    chk("mem_write_dat", mem_write_dat, e_wdat);
    chk("lock_ac", lock_ac, e_lac);
    chk("lock_held", lock_held, e_held);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic reset_cycle();
    idle(); reset = 1'b1;
    eval();
    advance();
    reset = 1'b0;
  endtask

  logic [C-1:0]  alt_ac  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [AW-1:0] alt_dat [4] = '{16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555};
  int            lsel    [3] = '{32'h001, 32'h002, 32'h123};

  initial begin
    idle(); reset = 1'b1;
    @(negedge clk);
    advance();
    eval();
    chk("reset_ac", main_mem_ac, 2'b00);
    chk("reset_held", lock_held, 2'b00);
    advance();
    reset = 1'b0;

    // Lone read by core0
    main_mem_read[0] = 1'b1; rd_adr[0] = 16'h0010;
    eval();
    chk("t1_ac", main_mem_ac, 2'b01);
    chk("t1_rd", mem_read, 1'b1);
    chk("t1_radr", mem_read_adr, 16'h0010);
    advance();
    main_mem_read = 2'b11;
    eval();
    chk("t1_ptr_moved", main_mem_ac, 2'b10);
    advance();

    // Saturating writers alternate
    reset_cycle();
    main_mem_write = 2'b11; wr_dat[0] = 16'hAAAA; wr_dat[1] = 16'h5555;
    wr_adr[0] = 16'h0100; wr_adr[1] = 16'h0200;
    for (int c = 0; c < 4; c++) begin
      eval();
      chk("t2_ac", main_mem_ac, alt_ac[c]);
      chk("t2_dat", mem_write_dat, alt_dat[c]);
      advance();
    end

    // Combined read+write from core1
    idle();
    main_mem_read[1] = 1'b1; rd_adr[1] = 16'h0003;
    main_mem_write[1] = 1'b1; wr_adr[1] = 16'h0004; wr_dat[1] = 16'hBEEF;
    eval();
    chk("t3_ac", main_mem_ac, 2'b10);
    chk("t3_rdwr", {mem_read, mem_write}, 2'b11);
    chk("t3_radr", mem_read_adr, 16'h0003);
    chk("t3_wadr", mem_write_adr, 16'h0004);
    chk("t3_wdat", mem_write_dat, 16'hBEEF);
    advance();

    // Contested lock on 0x123
    reset_cycle();
    lock_en = 2'b11; lock_adr[0] = 10'h123; lock_adr[1] = 10'h123;
    eval();
    chk("t4_lac", lock_ac, 2'b01);
    advance();
    lock_en = 2'b10;
    eval();
    chk("t4_held", lock_held, 2'b01);
    chk("t4_wait", lock_ac, 2'b00);
    advance();
    unlock_en[0] = 1'b1;
    eval();
    chk("t4_unlock_cycle", lock_ac, 2'b00);
    advance();
    unlock_en = '0;
    eval();
    chk("t4_after_unlock", lock_ac, 2'b10);
    advance();
    lock_en = '0; unlock_en[1] = 1'b1;
    eval();
    advance();
    idle();

    // Different addresses, re-entrant, wrong address
    lock_en = 2'b11; lock_adr[0] = 10'h001; lock_adr[1] = 10'h002;
    eval();
    chk("t5_both", lock_ac, 2'b11);
    advance();
    lock_en = 2'b01;
    eval();
    chk("t5_reentrant", lock_ac, 2'b01);
    chk("t5_held", lock_held, 2'b11);
    advance();
    lock_adr[0] = 10'h003;
    eval();
    chk("t5_other_adr", lock_ac, 2'b00);
    advance();
    idle(); unlock_en[1] = 1'b1;
    eval();
    advance();

    // Reset with lock held and a write pending
    idle(); main_mem_write[0] = 1'b1; wr_dat[0] = 16'h1234; reset = 1'b1;
    eval();
    chk("t6_wr_in_reset", mem_write, 1'b0);
    chk("t6_ac_in_reset", main_mem_ac, 2'b00);
    advance();
    reset = 1'b0; idle();
    lock_en[1] = 1'b1; lock_adr[1] = 10'h001;
    eval();
    chk("t6_held_cleared", lock_held, 2'b00);
    chk("t6_relock", lock_ac, 2'b10);
    advance();
    idle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      main_mem_read  = C'($urandom);
      main_mem_write = C'($urandom);
      for (int i = 0; i < C; i++) begin
        rd_adr[i]   = AW'($urandom);
        wr_adr[i]   = AW'($urandom);
        wr_dat[i]   = AW'($urandom);
        lock_adr[i] = LW'(lsel[$urandom_range(0, 2)]);
        lock_en[i]  = ($urandom_range(0, 1) == 1);
        unlock_en[i] = ($urandom_range(0, 5) == 0);
      end
      eval();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
